// File: rtl/lns_pkg.sv
// lns_pkg: shared widths and log-domain types for the Mitchell multiplier front end.
package lns_pkg;
  localparam int W      = 16;
  localparam int FRAC_W = 15;
  localparam int CHAR_W = 4;
  localparam int LOG_W  = 20;
  typedef struct packed {
    logic [CHAR_W-1:0] k;
    logic [FRAC_W-1:0] f;
  } log16_t;
  typedef logic [LOG_W-1:0] sumlog_t;
endpackage

// File: rtl/lod16.sv
// lod16: leading-one detector returning the characteristic and the left-aligned fraction.
module lod16
  import lns_pkg::*;
(
  input  logic [15:0] i_x,
  output log16_t      o_log,
  output logic        o_zero
);
  logic [3:0]  w_k;
  logic [14:0] w_f;
  always_comb begin
    w_k = '0;
    for (int i = 1; i < 16; i++) if (i_x[i]) w_k = 4'(i);
  end
  // Shifting by 15-k pushes the leading one out of the kept 15 bits; x=0 yields f=0.
  assign w_f    = 15'(i_x << (4'd15 - w_k));
  assign o_log  = '{k: w_k, f: w_f};
  assign o_zero = i_x == '0;
endmodule

// File: rtl/lns_sum_stage.sv
// lns_sum_stage: two-stage pipeline forming log2(a)+log2(b) with an explicit zero flag.
module lns_sum_stage #(
  parameter int W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     op_a,
  input  logic [W-1:0]     op_b,
  output logic             out_valid,
  input  logic             out_ready,
  output lns_pkg::sumlog_t sumlog,
  output logic             out_zero
);
  import lns_pkg::*;
  log16_t  w_la, w_lb;
  logic    w_za, w_zb, w_adv1, w_adv2;
  logic    r_s1_v, r_s2_v, r_z, r_zero;
  log16_t  r_a, r_b;
  sumlog_t r_sum;
  lod16 u_lod_a (.i_x(op_a), .o_log(w_la), .o_zero(w_za));
  lod16 u_lod_b (.i_x(op_b), .o_log(w_lb), .o_zero(w_zb));
  assign w_adv2    = !r_s2_v | out_ready;
  assign w_adv1    = !r_s1_v | w_adv2;
  assign in_ready  = w_adv1;
  assign out_valid = r_s2_v;
  assign sumlog    = r_sum;
  assign out_zero  = r_zero;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_v <= 1'b0;
      r_s2_v <= 1'b0;
      r_a    <= '0;
      r_b    <= '0;
      r_z    <= 1'b0;
      r_sum  <= '0;
      r_zero <= 1'b0;
    end else begin
      if (w_adv1) r_s1_v <= in_valid;
      if (w_adv1 & in_valid) begin
        r_a <= w_la;
        r_b <= w_lb;
        r_z <= w_za | w_zb;
      end
      if (w_adv2) r_s2_v <= r_s1_v;
      // Fraction carry ripples into the characteristic field; max 20'hFFFFE so no overflow.
      if (w_adv2 & r_s1_v) begin
        r_sum  <= r_z ? '0 : {1'b0, r_a} + {1'b0, r_b};
        r_zero <= r_z;
      end
    end
  end
endmodule

// File: tb/tb_lns_sum_stage.sv
// tb_lns_sum_stage: directed and randomized checks against an arithmetic log-sum model.
module tb_lns_sum_stage;
  logic        clk = 0, rst_n = 0, in_valid = 0, out_ready = 0;
  logic [15:0] op_a = 0, op_b = 0;
  logic        in_ready, out_valid, out_zero;
  logic [19:0] sumlog;
  int          tests = 0, fails = 0;
  logic [20:0] q[$];
  logic        acc_in, acc_out, has_exp, o_v, o_rdy, o_zero;
  logic [19:0] o_sum;
  logic [20:0] exp_v;

  lns_sum_stage #(.W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op_a(op_a), .op_b(op_b), .out_valid(out_valid), .out_ready(out_ready),
    .sumlog(sumlog), .out_zero(out_zero)
  );

  always #5 clk = ~clk;

  function automatic logic [20:0] model(int a, int b);
    int ka, kb, fa, fb;
    if (a == 0 || b == 0) return {1'b1, 20'h0};
    ka = $clog2(a + 1) - 1;
    kb = $clog2(b + 1) - 1;
    fa = (a - (1 << ka)) << (15 - ka);
    fb = (b - (1 << kb)) << (15 - kb);
    return {1'b0, 20'(ka * 32768 + fa + kb * 32768 + fb)};
  endfunction

  task automatic cyc(input logic v, input logic [15:0] a, input logic [15:0] b, input logic r);
    @(negedge clk);
    in_valid = v; op_a = a; op_b = b; out_ready = r;
    #1;
    o_v = out_valid; o_rdy = in_ready; o_sum = sumlog; o_zero = out_zero;
    acc_in = v & in_ready;
    acc_out = out_valid & r;
    has_exp = 0;
    exp_v = '0;
    if (acc_out && q.size() > 0) begin exp_v = q.pop_front(); has_exp = 1; end
    if (acc_in) q.push_back(model(int'(a), int'(b)));
  endtask

  task automatic test_reset;
    #1;
    tests++;
    if ({out_valid, out_zero, sumlog} !== 22'h0) begin
      fails++; $display("FAIL reset_outputs got v=%b z=%b s=%h want 0", out_valid, out_zero, sumlog);
    end
    @(negedge clk); rst_n = 1; #1;
    tests++;
    if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
  endtask

  task automatic test_directed;
    logic [15:0] va[6] = '{16'd1, 16'd3, 16'hFFFF, 16'd0, 16'd77, 16'd2};
    logic [15:0] vb[6] = '{16'd1, 16'd5, 16'hFFFF, 16'd1234, 16'd0, 16'd2};
    logic [20:0] ve[6] = '{21'h000000, 21'h01E000, 21'h0FFFFE, 21'h100000, 21'h100000, 21'h010000};
    for (int i = 0; i < 6; i++) begin
      cyc(1, va[i], vb[i], 1);
      cyc(0, 0, 0, 1);
      tests++;
      if (o_v !== 1'b0) begin fails++; $display("FAIL dir_latency_early[%0d] out_valid=%b want 0", i, o_v); end
      cyc(0, 0, 0, 1);
      tests++;
      if (o_v !== 1'b1 || {o_zero, o_sum} !== ve[i]) begin
        fails++; $display("FAIL dir_result[%0d] v=%b got %h want %h", i, o_v, {o_zero, o_sum}, ve[i]);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [20:0] want[3] = '{21'h01E000, 21'h000000, 21'h100000};
    int n = 0;
    cyc(1, 3, 5, 0);
    cyc(1, 1, 1, 0);
    for (int i = 0; i < 2; i++) begin
      cyc(1, 0, 9, 0);
      tests++;
      if (o_rdy !== 1'b0 || o_v !== 1'b1 || o_sum !== 20'h1E000 || o_zero !== 1'b0) begin
        fails++; $display("FAIL bp_hold[%0d] rdy=%b v=%b s=%h z=%b want rdy=0 v=1 s=1e000 z=0", i, o_rdy, o_v, o_sum, o_zero);
      end
    end
    cyc(1, 0, 9, 1);
    for (int i = 0; i < 10 && n < 3; i++) begin
      if (i > 0) cyc(0, 0, 0, 1);
      if (acc_out) begin
        tests++;
        if ({o_zero, o_sum} !== want[n]) begin
          fails++; $display("FAIL bp_order[%0d] got %h want %h", n, {o_zero, o_sum}, want[n]);
        end
        n++;
      end
    end
    tests++;
    if (n != 3) begin fails++; $display("FAIL bp_count got %0d want 3", n); end
  endtask

  task automatic test_random;
    logic        pv = 0;
    logic [20:0] ph = '0;
    logic [15:0] a, b;
    for (int i = 0; i < 400; i++) begin
      a = 16'($urandom);
      b = 16'($urandom);
      if ($urandom_range(7) == 0) a = 0;
      if ($urandom_range(7) == 0) b = 16'hFFFF;
      if ($urandom_range(9) == 0) b = 0;
      cyc(1'($urandom_range(3) != 0), a, b, 1'($urandom_range(3) != 0));
      if (pv) begin
        tests++;
        if (o_v !== 1'b1 || {o_zero, o_sum} !== ph) begin
          fails++; $display("FAIL rnd_stable cyc %0d v=%b got %h want %h", i, o_v, {o_zero, o_sum}, ph);
        end
      end
      pv = o_v & !out_ready;
      ph = {o_zero, o_sum};
      if (acc_out) begin
        tests++;
        if (!has_exp || {o_zero, o_sum} !== exp_v) begin
          fails++; $display("FAIL rnd_result cyc %0d got %h want %h (have=%b)", i, {o_zero, o_sum}, exp_v, has_exp);
        end
      end
    end
    for (int i = 0; i < 10 && q.size() > 0; i++) begin
      cyc(0, 0, 0, 1);
      if (acc_out) begin
        tests++;
        if (!has_exp || {o_zero, o_sum} !== exp_v) begin
          fails++; $display("FAIL rnd_drain got %h want %h", {o_zero, o_sum}, exp_v);
        end
      end
    end
    tests++;
    if (q.size() != 0) begin fails++; $display("FAIL rnd_lost got %0d pending want 0", q.size()); end
  endtask

  task automatic test_reset_mid;
    cyc(1, 2, 3, 0);
    cyc(1, 4, 5, 0);
    @(posedge clk); #2;
    in_valid = 0;
    rst_n = 0; #1;
    tests++;
    if (out_valid !== 1'b0 || sumlog !== 20'h0 || out_zero !== 1'b0) begin
      fails++; $display("FAIL mid_reset v=%b s=%h z=%b want 0", out_valid, sumlog, out_zero);
    end
    q.delete();
    @(negedge clk); rst_n = 1;
    cyc(1, 2, 2, 1);
    cyc(0, 0, 0, 1);
    tests++;
    if (o_v !== 1'b0) begin fails++; $display("FAIL mid_stale out_valid=%b want 0", o_v); end
    cyc(0, 0, 0, 1);
    tests++;
    if (o_v !== 1'b1 || {o_zero, o_sum} !== 21'h010000) begin
      fails++; $display("FAIL mid_after v=%b got %h want 010000", o_v, {o_zero, o_sum});
    end
    cyc(0, 0, 0, 1);
    tests++;
    if (o_v !== 1'b0) begin fails++; $display("FAIL mid_dup out_valid=%b want 0", o_v); end
  endtask

  initial begin
    test_reset;
    test_directed;
    test_back_to_back;
    test_random;
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
